// File: rtl/fpu_pkg.sv
// FP32 field widths, special encodings and pipeline stage payloads shared by the subtractor.
package fpu_pkg;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int MANT_W  = FRAC_W + 4;   // hidden + fraction + guard/round/sticky

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic              eff_sub;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant_l;
        logic [MANT_W-1:0] mant_s;
        logic              special;
        logic [31:0]       special_res;
    } s1_t;

    typedef struct packed {
        logic              sign;
        logic              eff_sub;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W:0]   sum;
        logic              special;
        logic [31:0]       special_res;
    } s2_t;
endpackage

// File: rtl/fp_sub_pipe_lzc.sv
// Leading-zero count of the 27-bit normalization window; zero flags an all-zero value.
module lzc (
    input  logic [26:0] value,
    output logic [4:0]  count,
    output logic        zero
);
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value[i]) count = 5'(26 - i);
        end
    end

    assign zero = ~|value;
endmodule

// File: rtl/fp_sub_pipe.sv
// Three-stage FP32 subtractor (align / add / normalize-round-pack) with valid-ready flow control.
// Define FP_SUB_RNE_EN for round-to-nearest-even; otherwise S3 truncates.
module fp_sub_pipe
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res
);
    logic s1_valid, s2_valid, s3_valid;
    logic en1, en2, en3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic [31:0] s3_d;

    assign en3       = !s3_valid || out_ready;
    assign en2       = !s2_valid || en3;
    assign en1       = !s1_valid || en2;
    assign in_ready  = en1;
    assign out_valid = s3_valid;

    // S1: unpack with b negated, order by magnitude, align the smaller mantissa
    logic        sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
    logic [7:0]  ea, eb, e_diff;
    logic [22:0] fa, fb;
    logic [23:0] ma, mb, m_small;
    logic [26:0] ms_full, ms_mask;

    always_comb begin
        sa      = a[31];
        sb      = ~b[31];
        ea      = a[30:23];
        eb      = b[30:23];
        a_zero  = (ea == 8'd0);
        b_zero  = (eb == 8'd0);
        a_inf   = (ea == 8'(EXP_MAX)) && (a[22:0] == 23'd0);
        b_inf   = (eb == 8'(EXP_MAX)) && (b[22:0] == 23'd0);
        a_nan   = (ea == 8'(EXP_MAX)) && (a[22:0] != 23'd0);
        b_nan   = (eb == 8'(EXP_MAX)) && (b[22:0] != 23'd0);
        fa      = a_zero ? 23'd0 : a[22:0];
        fb      = b_zero ? 23'd0 : b[22:0];
        ma      = {!a_zero, fa};
        mb      = {!b_zero, fb};
        a_big   = {ea, fa} >= {eb, fb};

        s1_d         = '0;
        s1_d.eff_sub = sa ^ sb;
        if (a_big) begin
            s1_d.sign   = sa;
            s1_d.exp    = ea;
            s1_d.mant_l = {ma, 3'b000};
            m_small     = mb;
            e_diff      = ea - eb;
        end else begin
            s1_d.sign   = sb;
            s1_d.exp    = eb;
            s1_d.mant_l = {mb, 3'b000};
            m_small     = ma;
            e_diff      = eb - ea;
        end

        ms_full = {m_small, 3'b000};
        ms_mask = ~(27'h7FF_FFFF << e_diff);
        if (e_diff >= 8'd27)
            s1_d.mant_s = {26'd0, |m_small};
        else
            s1_d.mant_s = (ms_full >> e_diff) | {26'd0, |(ms_full & ms_mask)};

        s1_d.special = a_nan | b_nan | a_inf | b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            s1_d.special_res = QNAN;
        else if (a_inf)
            s1_d.special_res = {sa, POS_INF[30:0]};
        else
            s1_d.special_res = {sb, POS_INF[30:0]};
    end

    // S2: magnitude add/subtract; mant_l >= mant_s so the difference never goes negative
    always_comb begin
        s2_d.sign        = s1_q.sign;
        s2_d.eff_sub     = s1_q.eff_sub;
        s2_d.exp         = s1_q.exp;
        s2_d.special     = s1_q.special;
        s2_d.special_res = s1_q.special_res;
        if (s1_q.eff_sub)
            s2_d.sum = {1'b0, s1_q.mant_l} - {1'b0, s1_q.mant_s};
        else
            s2_d.sum = {1'b0, s1_q.mant_l} + {1'b0, s1_q.mant_s};
    end

    // S3: fold carry-out into sticky, normalize, round, pack
    logic [26:0]       norm_in, shifted;
    logic [4:0]        lz;
    logic              nz;
    logic signed [9:0] exp_n, exp_r;
    logic [22:0]       frac;

    assign norm_in = s2_q.sum[27] ? {s2_q.sum[27:2], s2_q.sum[1] | s2_q.sum[0]} : s2_q.sum[26:0];

    lzc u_lzc (
        .value (norm_in),
        .count (lz),
        .zero  (nz)
    );

    always_comb begin
        shifted = norm_in << lz;
        exp_n   = $signed({2'b00, s2_q.exp}) + $signed({9'd0, s2_q.sum[27]}) - $signed({5'd0, lz});
    end

`ifdef FP_SUB_RNE_EN
    logic        round_up;
    logic [24:0] rounded;

    always_comb begin
        round_up = shifted[2] & (shifted[3] | shifted[1] | shifted[0]);
        rounded  = {1'b0, shifted[26:3]} + {24'd0, round_up};
        frac     = rounded[24] ? rounded[23:1] : rounded[22:0];
        exp_r    = exp_n + $signed({9'd0, rounded[24]});
    end
`else
    logic unused_grs;
    assign unused_grs = ^{shifted[26], shifted[2:0]};

    always_comb begin
        frac  = shifted[25:3];
        exp_r = exp_n;
    end
`endif

    always_comb begin
        s3_d = {s2_q.sign, exp_r[7:0], frac};
        if (s2_q.special)
            s3_d = s2_q.special_res;
        else if (nz)
            s3_d = {s2_q.sign & ~s2_q.eff_sub, 31'd0};
        else if (exp_r <= 10'sd0)
            s3_d = {s2_q.sign, 31'd0};
        else if (exp_r >= 10'(EXP_MAX))
            s3_d = {s2_q.sign, POS_INF[30:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            res      <= '0;
        end else begin
            if (en1) begin
                s1_valid <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (en2) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_q <= s2_d;
            end
            if (en3) begin
                s3_valid <= s2_valid;
                if (s2_valid) res <= s3_d;
            end
        end
    end
endmodule
